// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, exception codes and field positions.
package cp0_pkg;

  // CP0 register numbers (rd field of mtc0/mfc0)
  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  // SR field positions
  localparam int unsigned SR_IE     = 0;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IM_LSB = 10;

  // Cause field positions
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD      = 31;

  localparam int unsigned NUM_INT = 6;

endpackage

// File: rtl/cp0_sync.sv
// Two-flop synchronizer for the external interrupt lines.
module cp0_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  // Shift the raw lines through two stages; both clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= d;
      stage2 <= stage1;
    end
  end

  assign q = stage2;

endmodule

// File: rtl/cp0.sv
// Minimal MIPS-style CP0: SR, Cause, EPC, PRId, interrupt/RI exception entry and eret.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  sel,
  input  logic [31:0] wdata,
  input  logic [5:0]  hw_int,
  input  logic        op_exp,
  input  logic        eret,
  input  logic [31:0] pc,
  input  logic        bd,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_req
);

  logic [NUM_INT-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [4:0]         cause_exc;
  logic [31:0]        epc_r;
  logic [NUM_INT-1:0] ip;
  logic               hw_pend;

  cp0_sync #(
    .WIDTH (NUM_INT)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (hw_int),
    .q     (ip)
  );

  assign hw_pend = (|(ip & sr_im)) & sr_ie & ~sr_exl;
  // Gated by rst_n so a stray op_exp cannot raise a request while held in reset
  assign int_req = rst_n & (hw_pend | (op_exp & ~sr_exl));
  assign epc     = epc_r;

  // Exception entry wins over eret, which wins over mtc0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_exc <= '0;
      epc_r     <= '0;
    end else if (int_req) begin
      sr_exl    <= 1'b1;
      cause_bd  <= bd;
      epc_r     <= bd ? (pc - 32'd4) : pc;
      cause_exc <= hw_pend ? EXC_INT : EXC_RI;
    end else if (eret) begin
      sr_exl <= 1'b0;
    end else if (we) begin
      if (sel == SEL_SR) begin
        sr_im  <= wdata[SR_IM_LSB +: NUM_INT];
        sr_exl <= wdata[SR_EXL];
        sr_ie  <= wdata[SR_IE];
      end else if (sel == SEL_EPC) begin
        epc_r <= {wdata[31:2], 2'b00};
      end
    end
  end

  // mfc0 read mux from current register state
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_SR: begin
        rdata[SR_IM_LSB +: NUM_INT] = sr_im;
        rdata[SR_EXL]               = sr_exl;
        rdata[SR_IE]                = sr_ie;
      end
      SEL_CAUSE: begin
        rdata[CAUSE_BD]                = cause_bd;
        rdata[CAUSE_IP_LSB +: NUM_INT] = ip;
        rdata[CAUSE_EXC_LSB +: 5]      = cause_exc;
      end
      SEL_EPC:  rdata = epc_r;
      SEL_PRID: rdata = PRID;
      default:  rdata = '0;
    endcase
  end

endmodule
